uart_tx_buf_p: RTL

- Parametrised successor to the UART transmit buffer.
- A DATA_W-wide, 2^ADDR_W-deep flop-based FIFO sits between the application and the UART transmitter. The application may push one word per clk.
- A drain FSM pops one word, presents it with a one-cycle ready strobe, and waits for the transmitter's busy cycle before popping again.
- New versus the previous generation: full and occupancy outputs, sticky overflow, synchronous flush, a pause input, and a busy-rise timeout so a missed txBusy pulse cannot stall or double-send.

---
 rtl/uart_tx_buf_pkg.sv | 15 +
 rtl/uart_tx_buf_p_if.sv | 26 ++
 rtl/uart_tx_buf_p_sync_fifo.sv | 87 ++++++++
 rtl/uart_tx_buf_p.sv | 106 ++++++++++
 4 files changed

// File: rtl/uart_tx_buf_pkg.sv
// Shared constants for the parametrised UART transmit buffer:
// default parameter values and the drain FSM state encoding.
package uart_tx_buf_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_BUSY_TMO = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_POP     = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;

endpackage

// File: rtl/uart_tx_buf_p_if.sv
// Data handshake between the application, the transmit buffer and the
// UART transmitter. The buffer takes the slave side; whoever drives the
// application writes and the transmitter busy flag takes the master side.
interface uart_tx_buf_p_if
    import uart_tx_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] txdata;
    logic              txDataValid;
    logic              txBusy;
    logic [DATA_W-1:0] utb_txdata;
    logic              utb_txdata_rdy;

    modport master (
        output txdata, txDataValid, txBusy,
        input  utb_txdata, utb_txdata_rdy
    );

    modport slave (
        input  txdata, txDataValid, txBusy,
        output utb_txdata, utb_txdata_rdy
    );

endinterface

// File: rtl/uart_tx_buf_p_sync_fifo.sv
// Flop-based synchronous FIFO with registered status flags and a sticky
// overflow bit. Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo_p
    import uart_tx_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              pop_fire,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              emptyB,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              full_now;
    logic              empty_now;
    logic              accept;
    logic              drop;

    // The published flags lag the pointers by a cycle, so acceptance and
    // pop decisions look at the live pointers to never overrun or underrun.
    assign full_now  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty_now = (wr_ptr == rd_ptr);
    assign pop_fire  = pop && !flush && !empty_now;
    assign accept    = push && !flush && (!full_now || pop_fire);
    assign drop      = push && !flush && full_now && !pop_fire;
    assign rdata     = mem[rd_ptr[ADDR_W-1:0]];

    // Storage array, intentionally left without reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wdata;
        end
    end

    // Pointer update; flush discards everything by catching rd up to wr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered status flags and sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full     <= 1'b0;
            emptyB   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            full   <= full_now;
            emptyB <= !empty_now;
            count  <= wr_ptr - rd_ptr;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buf_p.sv
// UART transmit buffer: FIFO plus a drain FSM that pops one word, strobes
// it to the transmitter and waits out the transmitter's busy cycle.
//
// state   | meaning
// IDLE    | waiting for a word, not paused, no flush
// POP     | reading the FIFO head into the output register
// STROBE  | utb_txdata_rdy high for this single cycle
// WAIT_HI | waiting for txBusy to rise, bounded by BUSY_TMO cycles
// WAIT_LO | waiting for txBusy to fall
module uart_tx_buf_p
    import uart_tx_buf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BUSY_TMO = DEF_BUSY_TMO
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_tx_buf_p_if.slave  bus,
    input  logic            flush,
    input  logic            pause,
    input  logic            clr_ovf,
    output logic            full,
    output logic            emptyB,
    output logic [ADDR_W:0] count,
    output logic            overflow
);

    localparam int               TMR_W  = $clog2(BUSY_TMO + 1);
    localparam logic [TMR_W-1:0] TMO_LD = TMR_W'(BUSY_TMO);

    logic [2:0]        state;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rdata;
    logic              pop;
    logic              pop_fire;

    assign pop                = (state == ST_POP);
    assign bus.utb_txdata     = tx_q;
    assign bus.utb_txdata_rdy = (state == ST_STROBE);

    sync_fifo_p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (bus.txDataValid),
        .wdata    (bus.txdata),
        .pop      (pop),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .pop_fire (pop_fire),
        .rdata    (rdata),
        .full     (full),
        .emptyB   (emptyB),
        .count    (count),
        .overflow (overflow)
    );

    // Drain FSM with busy-rise timeout. POP falls back to IDLE when the pop
    // is suppressed (flush, or the lagging emptyB flag after a flush).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            timer <= '0;
            tx_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (emptyB && !pause && !flush) begin
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (pop_fire) begin
                        tx_q  <= rdata;
                        state <= ST_STROBE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_STROBE: begin
                    timer <= TMO_LD;
                    state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    timer <= timer - 1'b1;
                    if (bus.txBusy) begin
                        state <= ST_WAIT_LO;
                    end else if (timer == TMR_W'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT_LO: begin
                    if (!bus.txBusy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
